// File: rtl/lockbox_pkg.sv
// Shared lockbox front-end constants, FSM state encoding and frame-size helpers.
// Pure declarations: no latency, no flow control.
package lockbox_pkg;

    localparam logic       OP_GET       = 1'b0;
    localparam logic       OP_STORE     = 1'b1;

    localparam logic [7:0] OPC_GET      = 8'h00;
    localparam logic [7:0] OPC_STORE    = 8'h01;
    localparam logic [7:0] STATUS_OK    = 8'h00;
    localparam logic [7:0] STATUS_BADOP = 8'hEE;

    typedef logic [1:0] fe_state_t;
    localparam fe_state_t ST_RX    = 2'd0;
    localparam fe_state_t ST_ISSUE = 2'd1;
    localparam fe_state_t ST_WAIT  = 2'd2;
    localparam fe_state_t ST_TX    = 2'd3;

    // opcode + tag + secret + password
    function automatic int req_bytes(input int tag_w, input int w);
        return 1 + tag_w / 8 + 2 * (w / 8);
    endfunction

    // status + result
    function automatic int rsp_bytes(input int w);
        return 1 + w / 8;
    endfunction

    localparam int DEF_TAG_WIDTH = 16;
    localparam int DEF_WIDTH     = 128;
    localparam int REQ_BYTES     = req_bytes(DEF_TAG_WIDTH, DEF_WIDTH);
    localparam int RSP_BYTES     = rsp_bytes(DEF_WIDTH);

endpackage

// File: rtl/lockbox_frontend_if.sv
// Bundle of the front-end RX/TX byte streams and the lockbox request/result bus.
// master = front-end view; slave = the surrounding stream sources/sinks and core.
interface lockbox_frontend_if #(
    parameter int TAG_WIDTH = 16,
    parameter int WIDTH     = 128
);
    logic [7:0]           i_rx_data;
    logic                 i_rx_valid;
    logic                 o_rx_ready;
    logic [7:0]           o_tx_data;
    logic                 o_tx_valid;
    logic                 i_tx_ready;
    logic                 o_lb_en;
    logic                 o_lb_op;
    logic [TAG_WIDTH-1:0] o_lb_tag;
    logic [WIDTH-1:0]     o_lb_secret;
    logic [WIDTH-1:0]     o_lb_password;
    logic [WIDTH-1:0]     i_lb_out;
    logic                 i_lb_valid;

    modport master (
        input  i_rx_data, i_rx_valid,
        output o_rx_ready,
        output o_tx_data, o_tx_valid,
        input  i_tx_ready,
        output o_lb_en, o_lb_op, o_lb_tag, o_lb_secret, o_lb_password,
        input  i_lb_out, i_lb_valid
    );

    modport slave (
        output i_rx_data, i_rx_valid,
        input  o_rx_ready,
        input  o_tx_data, o_tx_valid,
        output i_tx_ready,
        input  o_lb_en, o_lb_op, o_lb_tag, o_lb_secret, o_lb_password,
        output i_lb_out, i_lb_valid
    );
endinterface

// File: rtl/lockbox_fe_ser.sv
// Response serializer: parallel-loads status+result, emits it MSB-first one byte per handshake.
// Output valid the cycle after load; byte held stable while i_tx_ready is low.
module lockbox_fe_ser
    import lockbox_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [WIDTH+7:0]   i_load_dat,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_done
);
    localparam int NBYTES = rsp_bytes(WIDTH);
    localparam int CW     = $clog2(NBYTES + 1);

    logic [WIDTH+7:0] r_sh;
    logic [CW-1:0]    r_cnt;
    logic             r_vld;
    logic             w_hs;
    logic             w_last;

    assign w_hs   = r_vld && i_tx_ready;
    assign w_last = (r_cnt == CW'(NBYTES - 1));

    // Shifting zeros in means the buffer is clear once the last byte leaves.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh  <= '0;
            r_cnt <= '0;
            r_vld <= 1'b0;
        end else if (i_load) begin
            r_sh  <= i_load_dat;
            r_cnt <= '0;
            r_vld <= 1'b1;
        end else if (w_hs) begin
            r_sh <= r_sh << 8;
            if (w_last) begin
                r_vld <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_tx_data  = r_sh[WIDTH+7 -: 8];
    assign o_tx_valid = r_vld;
    assign o_done     = w_hs && w_last;

endmodule

// File: rtl/lockbox_frontend.sv
// Lockbox byte-stream front-end: ISSUE 1 cycle after last RX byte, first TX byte 1 cycle after i_lb_valid.
// RX stalls (o_rx_ready=0) outside RX; TX holds data under backpressure. Option: LOCKBOX_FE_SCRUB_EN.
module lockbox_frontend
    import lockbox_pkg::*;
#(
    parameter int TAG_WIDTH = 16,
    parameter int WIDTH     = 128
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    lockbox_frontend_if.master bus
);
    localparam int NREQ = req_bytes(TAG_WIDTH, WIDTH);
    localparam int RB   = NREQ * 8;
    localparam int CW   = $clog2(NREQ + 1);

    fe_state_t        r_state;
    logic [CW-1:0]    r_rx_cnt;
    logic [RB-1:0]    r_req;
    logic             r_bad;

    logic             w_rx_hs;
    logic             w_rx_last;
    logic             w_opc_bad;
    logic             w_ser_load;
    logic [WIDTH+7:0] w_ser_dat;
    logic             w_tx_done;

    assign w_rx_hs   = (r_state == ST_RX) && bus.i_rx_valid;
    assign w_rx_last = (r_rx_cnt == CW'(NREQ - 1));
    assign w_opc_bad = (bus.i_rx_data != OPC_GET) && (bus.i_rx_data != OPC_STORE);

    // A bad-opcode frame skips the core and loads its error response directly.
    always_comb begin
        w_ser_load = 1'b0;
        w_ser_dat  = '0;
        if (w_rx_hs && w_rx_last && r_bad) begin
            w_ser_load = 1'b1;
            w_ser_dat  = {STATUS_BADOP, {WIDTH{1'b0}}};
        end else if ((r_state == ST_WAIT) && bus.i_lb_valid) begin
            w_ser_load = 1'b1;
            w_ser_dat  = {STATUS_OK, bus.i_lb_out};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_RX;
            r_rx_cnt <= '0;
            r_req    <= '0;
            r_bad    <= 1'b0;
        end else begin
            case (r_state)
                ST_RX: begin
                    if (w_rx_hs) begin
                        r_req <= {r_req[RB-9:0], bus.i_rx_data};
                        if (r_rx_cnt == '0) begin
                            r_bad <= w_opc_bad;
                        end
                        if (w_rx_last) begin
                            r_rx_cnt <= '0;
                            r_state  <= r_bad ? ST_TX : ST_ISSUE;
                        end else begin
                            r_rx_cnt <= r_rx_cnt + 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
`ifdef LOCKBOX_FE_SCRUB_EN
                    // The core sampled secret/password this cycle; drop our copy.
                    r_req[2*WIDTH-1:0] <= '0;
`endif
                end
                ST_WAIT: begin
                    if (bus.i_lb_valid) begin
                        r_state <= ST_TX;
                    end
                end
                ST_TX: begin
                    if (w_tx_done) begin
                        r_state <= ST_RX;
                    end
                end
                default: r_state <= ST_RX;
            endcase
        end
    end

    // Frame layout in r_req, MSB first: opcode | tag | secret | password.
    assign bus.o_rx_ready    = (r_state == ST_RX);
    assign bus.o_lb_en       = (r_state == ST_ISSUE);
    assign bus.o_lb_op       = (r_req[RB-1 -: 8] == OPC_STORE) ? OP_STORE : OP_GET;
    assign bus.o_lb_tag      = r_req[2*WIDTH +: TAG_WIDTH];
    assign bus.o_lb_secret   = r_req[WIDTH +: WIDTH];
    assign bus.o_lb_password = r_req[WIDTH-1:0];

    lockbox_fe_ser #(
        .WIDTH (WIDTH)
    ) u_ser (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_ser_load),
        .i_load_dat (w_ser_dat),
        .o_tx_data  (bus.o_tx_data),
        .o_tx_valid (bus.o_tx_valid),
        .i_tx_ready (bus.i_tx_ready),
        .o_done     (w_tx_done)
    );

endmodule

// File: tb/tb_lockbox_frontend.sv
// Bench for lockbox_frontend: directed + randomized frames against a bench-side lockbox/scoreboard model.
module tb_lockbox_frontend;
    import lockbox_pkg::*;

    localparam int TW   = 16;
    localparam int W    = 128;
    localparam int NREQ = 35;
    localparam int NRSP = 17;

    logic clk;
    logic rst_n;

    lockbox_frontend_if #(.TAG_WIDTH(TW), .WIDTH(W)) bus ();

    lockbox_frontend #(.TAG_WIDTH(TW), .WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Core model side
    logic          core_valid = 1'b0;
    logic          spur_valid = 1'b0;
    logic [W-1:0]  core_out   = '0;
    logic [W-1:0]  spur_out   = '0;
    assign bus.i_lb_valid = core_valid | spur_valid;
    assign bus.i_lb_out   = spur_valid ? spur_out : core_out;

    logic [2*W-1:0] core_mem [logic [TW-1:0]];
    logic [2*W-1:0] pred_mem [logic [TW-1:0]];

    int            en_count  = 0;
    int            lat_bad   = 0;
    int            stab_bad  = 0;
    int            scrub_bad = 0;
    bit            pending   = 0;
    int            wcnt      = 0;
    logic          cap_op;
    logic [TW-1:0] cap_tag;
    logic [W-1:0]  cap_sec, cap_pw, resp_val;

    // Behavioural lockbox: store answers 1, get answers the secret only on password match.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                core_valid = 1'b0;
                pending    = 0;
            end else begin
                if (core_valid) begin
                    if (bus.o_tx_valid !== 1'b1) lat_bad++;
                    core_valid = 1'b0;
                end else if (pending) begin
                    if (bus.o_lb_tag !== cap_tag || bus.o_lb_op !== cap_op || bus.o_lb_en !== 1'b0) stab_bad++;
`ifdef LOCKBOX_FE_SCRUB_EN
                    if (bus.o_lb_secret !== '0 || bus.o_lb_password !== '0) scrub_bad++;
`else
                    if (bus.o_lb_secret !== cap_sec || bus.o_lb_password !== cap_pw) stab_bad++;
`endif
                    if (wcnt == 0) begin
                        core_valid = 1'b1;
                        core_out   = resp_val;
                        pending    = 0;
                    end else begin
                        wcnt--;
                    end
                end
                if (bus.o_lb_en === 1'b1) begin
                    en_count++;
                    cap_op  = bus.o_lb_op;
                    cap_tag = bus.o_lb_tag;
                    cap_sec = bus.o_lb_secret;
                    cap_pw  = bus.o_lb_password;
                    if (cap_op) begin
                        core_mem[cap_tag] = {cap_sec, cap_pw};
                        resp_val = W'(1);
                    end else if (core_mem.exists(cap_tag) && core_mem[cap_tag][W-1:0] == cap_pw) begin
                        resp_val = core_mem[cap_tag][2*W-1:W];
                    end else begin
                        resp_val = '0;
                    end
                    pending = 1;
                    wcnt    = $urandom_range(0, 3);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_w();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic send_frame(input logic [7:0] opc, input logic [TW-1:0] tag,
                              input logic [W-1:0] sec, input logic [W-1:0] pw,
                              input int nbytes, input int spur_at);
        logic [7:0] b [NREQ];
        int t;
        b[0] = opc;
        b[1] = tag[15:8];
        b[2] = tag[7:0];
        for (int i = 0; i < 16; i++) begin
            b[3 + i]  = sec[W-1-8*i -: 8];
            b[19 + i] = pw[W-1-8*i -: 8];
        end
        for (int i = 0; i < nbytes; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.i_rx_valid = 1'b0;
                @(negedge clk);
            end
            bus.i_rx_data  = b[i];
            bus.i_rx_valid = 1'b1;
            if (i == spur_at) begin
                spur_valid = 1'b1;
                spur_out   = rnd_w();
            end
            t = 0;
            while (bus.o_rx_ready !== 1'b1 && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) chk("rx_ready_timeout", bus.o_rx_ready, 1'b1);
            @(negedge clk);
            spur_valid = 1'b0;
        end
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic recv_frame(input logic [7:0] st, input logic [W-1:0] res,
                              input int stall_at, input int stall_len);
        logic [7:0] e [NRSP];
        logic [7:0] prev_d = 8'h00;
        bit         prev_stall = 0;
        bit         rdy;
        int         got = 0;
        int         t = 0;
        int         scnt = 0;
        e[0] = st;
        for (int i = 0; i < 16; i++) e[1 + i] = res[W-1-8*i -: 8];
        while (got < NRSP && t < 2000) begin
            rdy = ($urandom_range(0, 3) != 0);
            if (bus.o_tx_valid === 1'b1) begin
                if (prev_stall) chk("bp_hold_data", bus.o_tx_data, prev_d);
                if (got == 1) chk("rx_blocked_in_tx", bus.o_rx_ready, 1'b0);
                if (got == stall_at && scnt < stall_len) begin
                    rdy = 1'b0;
                    scnt++;
                end
                if (rdy) begin
                    chk($sformatf("tx_byte%0d", got), bus.o_tx_data, e[got]);
                    got++;
                    prev_stall = 0;
                end else begin
                    prev_stall = 1;
                    prev_d     = bus.o_tx_data;
                end
            end else if (prev_stall) begin
                chk("bp_hold_valid", bus.o_tx_valid, 1'b1);
                prev_stall = 0;
            end
            bus.i_tx_ready = rdy;
            @(negedge clk);
            t++;
        end
        bus.i_tx_ready = 1'b0;
        chk("tx_byte_count", got, NRSP);
        chk("tx_idle_after", bus.o_tx_valid, 1'b0);
        chk("rx_ready_after", bus.o_rx_ready, 1'b1);
`ifdef LOCKBOX_FE_SCRUB_EN
        chk("result_scrubbed", bus.o_tx_data, 8'h00);
`endif
    endtask

    task automatic do_frame(input logic [7:0] opc, input logic [TW-1:0] tag,
                            input logic [W-1:0] sec, input logic [W-1:0] pw,
                            input int stall_at, input int spur_at);
        bit           bad;
        logic [7:0]   st;
        logic [W-1:0] res;
        int           e0;
        bad = (opc != 8'h00) && (opc != 8'h01);
        if (bad) begin
            st = 8'hEE; res = '0;
        end else if (opc == 8'h01) begin
            st = 8'h00; res = W'(1);
            pred_mem[tag] = {sec, pw};
        end else begin
            st  = 8'h00;
            res = (pred_mem.exists(tag) && pred_mem[tag][W-1:0] == pw) ? pred_mem[tag][2*W-1:W] : '0;
        end
        e0 = en_count;
        send_frame(opc, tag, sec, pw, NREQ, spur_at);
        if (!bad) begin
            chk("issue_strobe", bus.o_lb_en, 1'b1);
            chk("lb_op", bus.o_lb_op, opc[0]);
            chk("lb_tag", bus.o_lb_tag, tag);
            chk("lb_secret", bus.o_lb_secret, sec);
            chk("lb_password", bus.o_lb_password, pw);
        end else begin
            chk("badop_no_en", bus.o_lb_en, 1'b0);
            chk("badop_tx_now", bus.o_tx_valid, 1'b1);
        end
        recv_frame(st, res, stall_at, 5);
        chk("en_pulses", en_count - e0, bad ? 1'b0 : 1'b1);
        chk("lat_to_tx", lat_bad, 0);
        chk("wait_stable", stab_bad, 0);
        chk("scrub_wait", scrub_bad, 0);
    endtask

    logic [W-1:0]  seq_sec, seq_pw;
    logic [TW-1:0] tags [3];

    initial begin
        bus.i_rx_data  = 8'h00;
        bus.i_rx_valid = 1'b0;
        bus.i_tx_ready = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            seq_sec[W-1-8*i -: 8] = 8'(i);
            seq_pw[W-1-8*i -: 8]  = 8'(8'hF0 + i);
        end
        tags[0] = 16'h002A; tags[1] = 16'h1234; tags[2] = 16'hBEEF;
        repeat (2) @(negedge clk);
        chk("rst_tx_valid", bus.o_tx_valid, 1'b0);
        chk("rst_lb_en", bus.o_lb_en, 1'b0);
        chk("rst_tx_data", bus.o_tx_data, 8'h00);
        chk("rst_lb_op", bus.o_lb_op, 1'b0);
        chk("rst_lb_tag", bus.o_lb_tag, 16'h0);
        chk("rst_lb_secret", bus.o_lb_secret, 128'h0);
        chk("rst_lb_password", bus.o_lb_password, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rx_ready", bus.o_rx_ready, 1'b1);

        // Store then matching get
        do_frame(8'h01, 16'h002A, seq_sec, seq_pw, -1, -1);
        do_frame(8'h00, 16'h002A, seq_sec ^ rnd_w(), seq_pw, -1, -1);
        // Bad opcode, then a legal frame with wrong password
        do_frame(8'h07, 16'($urandom()), rnd_w(), rnd_w(), -1, -1);
        do_frame(8'h00, 16'h002A, '0, ~seq_pw, -1, -1);
        // Forced 5-cycle TX stall mid-response
        do_frame(8'h00, 16'h002A, '0, seq_pw, 8, -1);

        // Reset after 10 RX bytes, then a fresh frame
        send_frame(8'h01, 16'h1234, rnd_w(), rnd_w(), 10, -1);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx_valid", bus.o_tx_valid, 1'b0);
        chk("midrst_lb_en", bus.o_lb_en, 1'b0);
        chk("midrst_lb_tag", bus.o_lb_tag, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_rx_ready", bus.o_rx_ready, 1'b1);
        do_frame(8'h01, 16'h1234, rnd_w(), rnd_w(), -1, -1);

        // Spurious core strobe during RX
        do_frame(8'h00, 16'h1234, '0, pred_mem[16'h1234][W-1:0], -1, 5);

        for (int k = 0; k < 12; k++) begin
            int            r;
            logic [7:0]    opc;
            logic [TW-1:0] tg;
            logic [W-1:0]  pw;
            r  = $urandom_range(0, 9);
            opc = (r < 4) ? 8'h01 : (r < 8) ? 8'h00 : 8'($urandom_range(2, 255));
            tg = tags[$urandom_range(0, 2)];
            pw = rnd_w();
            if (opc == 8'h00 && pred_mem.exists(tg) && $urandom_range(0, 1) == 1)
                pw = pred_mem[tg][W-1:0];
            do_frame(opc, tg, rnd_w(), pw, ($urandom_range(0, 2) == 0) ? $urandom_range(0, 16) : -1,
                     ($urandom_range(0, 3) == 0) ? $urandom_range(0, 34) : -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
